// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M-style multiply/divide unit.
//   One product bit (shift-add) or quotient bit (restoring divide) per cycle,
//   then a single fix-up cycle that applies signs and selects the output half.
//   Divide-by-zero and signed-divide overflow are resolved at acceptance.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, op, a, b       request (funct3 op), taken when busy=0
//   kill                  abort an in-flight operation (no done)
//   busy                  high in CALC and FIX
//   done                  one-cycle pulse with result valid
//   result, div_by_zero   registered, held until the next done
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             kill,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   mag_b_q, mag_b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               dbz_q, dbz_d;

   // acceptance-time decode
   logic             a_sgn, b_sgn, a_neg, b_neg, accept, b_zero, div_ovf, res_neg;
   logic [WIDTH-1:0] mag_a, mag_b, spec_res;

   assign a_sgn   = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                    (op == OP_DIV) || (op == OP_REM);
   assign b_sgn   = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   assign a_neg   = a_sgn && a[WIDTH-1];
   assign b_neg   = b_sgn && b[WIDTH-1];
   assign mag_a   = a_neg ? -a : a;
   assign mag_b   = b_neg ? -b : b;
   assign accept  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign b_zero  = (b == '0);
   assign div_ovf = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == ALL_ONES);
   // op[1] distinguishes REM/REMU from DIV/DIVU
   assign spec_res = b_zero ? (op[1] ? a : ALL_ONES) : (op[1] ? '0 : a);
   // remainder follows the dividend's sign; everything else the sign product
   assign res_neg  = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);

   // iteration datapath: low half of acc holds multiplier / dividend bits
   logic [WIDTH:0]     mul_sum, div_up;
   logic [WIDTH-1:0]   div_diff, div_sel, div_fix;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod_fix;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
   assign div_up   = acc_q[2*WIDTH-1:WIDTH-1];
   // a successful subtract always leaves less than the divisor, so WIDTH bits suffice
   assign div_diff = div_up[WIDTH-1:0] - mag_b_q;
   assign div_ge   = (div_up >= {1'b0, mag_b_q});
   assign prod_fix = neg_q ? -acc_q : acc_q;
   assign div_sel  = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
   assign div_fix  = neg_q ? -div_sel : div_sel;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         neg_q    <= 1'b0;
         mag_b_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         mag_b_q  <= mag_b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         dbz_q    <= dbz_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_d    = neg_q;
      mag_b_d  = mag_b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      dbz_d    = dbz_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               op_d    = op;
               neg_d   = res_neg;
               mag_b_d = mag_b;
               acc_d   = {{WIDTH{1'b0}}, mag_a};
               cnt_d   = CNT_INIT;
               if (op[2] && (b_zero || div_ovf)) begin
                  result_d = spec_res;
                  dbz_d    = b_zero;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (kill) begin
               state_d = S_IDLE;
            end else begin
               if (!op_q[2]) begin
                  acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               end else if (div_ge) begin
                  acc_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = {div_up[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (kill) begin
               state_d = S_IDLE;
            end else begin
               if (op_q[2])            result_d = div_fix;
               else if (op_q == OP_MUL) result_d = prod_fix[WIDTH-1:0];
               else                     result_d = prod_fix[2*WIDTH-1:WIDTH];
               dbz_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
   assign done        = (state_q == S_DONE);
   assign result      = result_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit; the multicycle successor to the single-cycle ALU, implementing the RV32M operations. The multicycle core issues an operation with a start pulse and waits on done. It processes one product or quotient bit per cycle and resolves the RISC-V divide-by-zero and signed-overflow corner cases without iterating. Width is generic, so the same block serves RV32 and RV64-style datapaths.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 4
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when busy=0
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  WIDTH  rs1 operand, sampled on acceptance
- b  in  WIDTH  rs2 operand, sampled on acceptance
- kill  in  1  abort in-flight operation
- busy  out  1  operation in flight (CALC or FIX)
- done  out  1  one-cycle pulse: result valid
- result  out  WIDTH  registered result, held until the next done
- div_by_zero  out  1  registered; set with done for DIV/DIVU/REM/REMU when b==0, otherwise cleared with done

## Operation
- States: IDLE, CALC, FIX, DONE. busy=1 in CALC and FIX only.
- IDLE/DONE with start=1: latch op, a and b. Latch magnitudes: |a| if op is MUL, MULH, MULHSU, DIV or REM; |b| if op is MUL, MULH, DIV or REM. Record the result sign. Load counter=WIDTH, then go to CALC.
- Special cases are detected at acceptance and skip CALC/FIX, going straight to DONE:
  - div/rem with b==0: DIV/DIVU give all-ones, REM/REMU give a.
  - DIV with a = most negative and b = all-ones: quotient = a, REM = 0.
- CALC, multiply: shift-add over a 2·WIDTH product register, one multiplier bit per cycle.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle. Counter decrements each cycle; at counter==1, go to FIX.
- FIX: apply two's-complement negation as needed.
  - MUL/MULH/MULHSU: negate if operand signs differ.
  - DIV: negate if operand signs differ.
  - REM: remainder takes the sign of a.
  - Select output: MUL gives low WIDTH bits; MULH* give high WIDTH bits; DIV* give the quotient; REM* give the remainder.
  - Write result, go to DONE.
- DONE: done=1 for exactly one cycle. Next state is IDLE, or CALC/DONE if start=1 is accepted in this cycle (back-to-back issue).
- kill in CALC or FIX: next state IDLE. No done is produced; result and div_by_zero keep their prior values. kill in IDLE/DONE has no effect, and start in the same cycle is still accepted.
- start while busy=1 is ignored; no queueing.
- All arithmetic is modulo 2^WIDTH. Internal product/remainder registers are 2·WIDTH wide; the counter is $clog2(WIDTH)+1 bits.

## Timing
- Reset (asynchronous, reset_n low): state IDLE, busy=0, done=0, result=0, div_by_zero=0, counter=0. Assertion mid-CALC aborts immediately and leaves no residual done.
- Acceptance edge is k (start=1, busy=0).
- Normal op: busy=1 in cycles k+1 … k+WIDTH+1. done=1 and result valid in cycle k+WIDTH+2, i.e. 34 cycles after acceptance for WIDTH=32.
- Special case: done=1 in cycle k+1, busy stays 0.
- Back-to-back: start in the DONE cycle is accepted at that edge; the next done arrives at the same latency counted from that edge.
- kill sampled at edge j during CALC/FIX: busy=0 from cycle j+1.

## Test plan
- MUL a=7, b=0xFFFFFFFD (WIDTH=32) -> result 0xFFFFFFEB; done only in cycle k+34; busy high for exactly 33 cycles.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Division:
  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM of the same -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - div_by_zero=0 on all of these.
- Special cases:
  - DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234; div_by_zero=1; done at k+1.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Abort and reset:
  - kill at k+10 of a DIV -> busy=0 at k+11, no done within 40 cycles, result keeps the previous value.
  - reset_n low at k+5 -> all outputs 0 immediately.
- Handshake:
  - start pulsed at k+3 while busy -> ignored; the first result is unaffected.
  - start with new operands in the DONE cycle -> accepted, and the second done follows 34 cycles later.
- Run the directed cases of the first scenarios at WIDTH=8, checked against a reference model.
